// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller: stage enables, bubbles and fetch redirect, with priority
// ERROR > dmem freeze > EX mispredict > load-use > ID redirect > imem stall; controls are combinational.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             stage_clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_redirect,
  input  logic [31:0]      id_target,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_pc_plus4,
  input  logic             imem_ready,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             if_ena,
  output logic             if_x,
  output logic             id_ena,
  output logic             id_x,
  output logic             ex_ena,
  output logic             mem_ena,
  output logic             take_new_pc,
  output logic [31:0]      pc_new,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          freeze, mispredict, load_use, err_set, stall_inc;

  assign freeze     = mem_access & ~dmem_ready;
  assign mispredict = ex_br_valid & (ex_br_taken != ex_pred_taken);
  assign load_use   = ex_is_load & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign err_set    = (state == MEM_WAIT) & freeze & (timer == TMAX);
  assign stall_inc  = (state != ERROR) & (freeze | load_use | ~imem_ready);

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      timer        <= '0;
      bus_error    <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      bus_error <= bus_error | err_set;
      if (stall_inc)
        stall_cycles <= stall_cycles + 1'b1;
      if (take_new_pc)
        flush_count <= flush_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEM_WAIT;
          timer_nxt = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          if (timer == TMAX)
            state_nxt = ERROR;
          else
            timer_nxt = timer + 1'b1;
        end else begin
          state_nxt = RUN;
          timer_nxt = '0;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  // A mispredict seen during a freeze needs no storage: EX is held, so it reappears on release.
  always_comb begin
    if_ena      = 1'b1;
    if_x        = 1'b0;
    id_ena      = 1'b1;
    id_x        = 1'b0;
    ex_ena      = 1'b1;
    mem_ena     = 1'b1;
    take_new_pc = 1'b0;
    pc_new      = 32'd0;
    if (state == ERROR || freeze) begin
      if_ena  = 1'b0;
      id_ena  = 1'b0;
      ex_ena  = 1'b0;
      mem_ena = 1'b0;
    end else if (mispredict) begin
      take_new_pc = 1'b1;
      pc_new      = ex_br_taken ? ex_target : ex_pc_plus4;
      if_x        = 1'b1;
      id_x        = 1'b1;
    end else if (load_use) begin
      if_ena = 1'b0;
      id_x   = 1'b1;
    end else if (id_redirect) begin
      take_new_pc = 1'b1;
      pc_new      = id_target;
      if_x        = 1'b1;
    end else if (!imem_ready) begin
      if_ena = 1'b0;
      id_x   = 1'b1;
    end
  end

endmodule
